// File: rtl/lbist_ctrl.sv
// Logic-BIST controller: LFSR pattern source, MISR compactor and test sequencing FSM.
// Optional run abort input enabled by defining LBIST_ABORT_EN.
module lbist_ctrl #(
  parameter int                    N_CHAINS   = 8,
  parameter int                    CHAIN_LEN  = 64,
  parameter int                    N_PATTERNS = 1024,
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h8020_0003,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 32'hACE1_0001,
  parameter int                    MISR_WIDTH = 32,
  parameter logic [MISR_WIDTH-1:0] MISR_POLY  = 32'h04C1_1DB7,
  parameter logic [MISR_WIDTH-1:0] GOLDEN_SIG = 32'h0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
`ifdef LBIST_ABORT_EN
  input  logic                              abort_i,
`endif
  input  logic [N_CHAINS-1:0]               scan_out_i,
  output logic [N_CHAINS-1:0]               scan_in_o,
  output logic                              scan_en_o,
  output logic                              test_mode_o,
  output logic                              clock_en_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              pass_o,
  output logic [MISR_WIDTH-1:0]             signature_o,
  output logic [$clog2(N_PATTERNS+1)-1:0]   pattern_cnt_o
);

  localparam int CNT_W = $clog2(N_PATTERNS + 1);
  localparam int SC_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [SC_W-1:0]  SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] PAT_LAST   = CNT_W'(N_PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [LFSR_WIDTH-1:0]   r_lfsr;
  logic [MISR_WIDTH-1:0]   r_misr;
  logic [CNT_W-1:0]        r_patternCnt;
  logic [SC_W-1:0]         r_shiftCnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;

  logic                    w_abort;
  logic                    w_inTest;
  logic                    w_busyNext;
  logic                    w_scanEn;
  logic                    w_lastShift;
  logic [LFSR_WIDTH-1:0]   w_lfsrNext;
  logic [MISR_WIDTH-1:0]   w_misrNext;

`ifdef LBIST_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  assign w_inTest    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_busyNext  = (w_stateNext != S_IDLE) && (w_stateNext != S_DONE);
  assign w_scanEn    = (r_state == S_SHIFT) || (r_state == S_UNLOAD);
  assign w_lastShift = (r_shiftCnt == SHIFT_LAST);

  assign w_lfsrNext = {r_lfsr[LFSR_WIDTH-2:0], ^(r_lfsr & LFSR_POLY)};
  assign w_misrNext = {r_misr[MISR_WIDTH-2:0], 1'b0}
                    ^ (r_misr[MISR_WIDTH-1] ? MISR_POLY : '0)
                    ^ MISR_WIDTH'(scan_out_i);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_stateNext = S_SEED;
      S_SEED:    w_stateNext = S_SHIFT;
      S_SHIFT:   if (w_lastShift) w_stateNext = S_CAPTURE;
      S_CAPTURE: w_stateNext = (r_patternCnt == PAT_LAST) ? S_UNLOAD : S_SHIFT;
      S_UNLOAD:  if (w_lastShift) w_stateNext = S_COMPARE;
      S_COMPARE: w_stateNext = S_DONE;
      S_DONE:    if (start_i) w_stateNext = S_SEED;
      default:   w_stateNext = S_IDLE;
    endcase
    if (w_abort && w_inTest) w_stateNext = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_misr       <= '0;
      r_patternCnt <= '0;
      r_shiftCnt   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_busy  <= w_busyNext;
      r_done  <= (w_stateNext == S_DONE);
      if (w_stateNext == S_SEED) r_pass <= 1'b0;
      case (r_state)
        S_SEED: begin
          r_lfsr       <= LFSR_SEED;
          r_misr       <= '0;
          r_patternCnt <= '0;
          r_shiftCnt   <= '0;
        end
        // The unload during the first load is pre-test core state, so it is not compacted.
        S_SHIFT: begin
          r_lfsr     <= w_lfsrNext;
          r_shiftCnt <= w_lastShift ? '0 : r_shiftCnt + 1'b1;
          if (r_patternCnt != '0) r_misr <= w_misrNext;
        end
        S_CAPTURE: r_patternCnt <= r_patternCnt + 1'b1;
        S_UNLOAD: begin
          r_lfsr     <= w_lfsrNext;
          r_misr     <= w_misrNext;
          r_shiftCnt <= w_lastShift ? '0 : r_shiftCnt + 1'b1;
        end
        S_COMPARE: r_pass <= (r_misr == GOLDEN_SIG);
        default: ;
      endcase
      if (w_abort && w_inTest) begin
        r_misr <= '0;
        r_pass <= 1'b0;
      end
    end
  end

  assign scan_in_o     = w_scanEn ? r_lfsr[N_CHAINS-1:0] : '0;
  assign scan_en_o     = w_scanEn;
  assign test_mode_o   = w_inTest;
  assign clock_en_o    = !w_inTest || (r_state == S_SHIFT) ||
                         (r_state == S_CAPTURE) || (r_state == S_UNLOAD);
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign pass_o        = r_pass;
  assign signature_o   = r_misr;
  assign pattern_cnt_o = r_patternCnt;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Directed self-checking bench for lbist_ctrl: small 2x4x3 instance plus a
// longer single-chain instance whose run is long enough to engage the MISR polynomial.
module tb_lbist_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [1:0]  scanOut;
  logic [1:0]  scanIn;
  logic        scanEn, testMode, clockEn, busy, done, pass;
  logic [31:0] signature;
  logic [1:0]  patternCnt;
  logic        abort;

  logic        startL;
  logic        scanOutL;
  logic        scanInL;
  logic        scanEnL, testModeL, clockEnL, busyL, doneL, passL;
  logic [31:0] signatureL;
  logic [1:0]  patternCntL;

  int testsRun    = 0;
  int testsFailed = 0;

  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] LPOLY = 32'h8020_0003;
  localparam logic [31:0] MPOLY = 32'h04C1_1DB7;

  always #5 clk = ~clk;

  lbist_ctrl #(.N_CHAINS(2), .CHAIN_LEN(4), .N_PATTERNS(3), .GOLDEN_SIG(32'h0)) u_dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(start),
`ifdef LBIST_ABORT_EN
    .abort_i(abort),
`endif
    .scan_out_i(scanOut), .scan_in_o(scanIn), .scan_en_o(scanEn),
    .test_mode_o(testMode), .clock_en_o(clockEn), .busy_o(busy), .done_o(done),
    .pass_o(pass), .signature_o(signature), .pattern_cnt_o(patternCnt)
  );

  lbist_ctrl #(.N_CHAINS(1), .CHAIN_LEN(20), .N_PATTERNS(2), .GOLDEN_SIG(32'h0)) u_dutLong (
    .clk_i(clk), .rst_ni(rstN), .start_i(startL),
`ifdef LBIST_ABORT_EN
    .abort_i(1'b0),
`endif
    .scan_out_i(scanOutL), .scan_in_o(scanInL), .scan_en_o(scanEnL),
    .test_mode_o(testModeL), .clock_en_o(clockEnL), .busy_o(busyL), .done_o(doneL),
    .pass_o(passL), .signature_o(signatureL), .pattern_cnt_o(patternCntL)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] lfsrModel(input logic [31:0] v);
    return {v[30:0], ^(v & LPOLY)};
  endfunction

  function automatic logic [31:0] misrModel(input logic [31:0] m, input logic [31:0] din);
    return {m[30:0], 1'b0} ^ (m[31] ? MPOLY : 32'h0) ^ din;
  endfunction

  // Cycle c counts from 1 = SEED; scan_out is driven for the state of cycle c.
  function automatic logic [1:0] stimFor(input int mode, input int c);
    case (mode)
      1: return (c == 20) ? 2'b01 : 2'b00;
      2: return (c >= 2 && c <= 5) ? 2'b11 : 2'b00;
      3: return (c == 19 || c == 20) ? 2'b01 : 2'b00;
      4: return (c == 7) ? 2'b10 : 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  task automatic applyStimulus(input int mode, input int resetAt, input int abortAt,
                               output int busyCycles, output int doneCycle);
    logic [31:0] model;
    model = SEED;
    busyCycles = 0;
    doneCycle = 0;
    @(negedge clk);
    start = 1'b1;
    scanOut = 2'b00;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 200 && doneCycle == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (busy) busyCycles++;
      if (done) doneCycle = c;
      if (c == 1) begin
        checkOutput("done cleared in SEED", 32'(done), 32'd0);
        checkOutput("test_mode in SEED", 32'(testMode), 32'd1);
      end
      if (mode == 0) begin
        if ((c >= 2 && c <= 5) || (c >= 7 && c <= 10) || (c >= 12 && c <= 15)) begin
          checkOutput("scan_in vs lfsr model", 32'(scanIn), 32'(model[1:0]));
          model = lfsrModel(model);
        end
        if (c == 2) checkOutput("scan_in first shift", 32'(scanIn), 32'd1);
        if (c == 3) checkOutput("scan_in second shift", 32'(scanIn), 32'd3);
        if (c == 1) checkOutput("clock_en in SEED", 32'(clockEn), 32'd0);
        if (c == 2) checkOutput("scan_en in SHIFT", 32'(scanEn), 32'd1);
        if (c == 6) checkOutput("scan_en in CAPTURE", 32'(scanEn), 32'd0);
        if (c == 6) checkOutput("clock_en in CAPTURE", 32'(clockEn), 32'd1);
        if (c == 17) checkOutput("scan_en in UNLOAD", 32'(scanEn), 32'd1);
        if (c == 21) checkOutput("clock_en in COMPARE", 32'(clockEn), 32'd0);
        if (c == 22) checkOutput("clock_en in DONE", 32'(clockEn), 32'd1);
      end
      if (c == resetAt) begin
        checkOutput("pattern_cnt before reset", 32'(patternCnt), 32'd2);
        rstN = 1'b0;
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset test_mode", 32'(testMode), 32'd0);
        checkOutput("reset clock_en", 32'(clockEn), 32'd1);
        checkOutput("reset scan_en", 32'(scanEn), 32'd0);
        checkOutput("reset signature", signature, 32'd0);
        checkOutput("reset pattern_cnt", 32'(patternCnt), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        doneCycle = -1;
      end
      if (c == abortAt) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort test_mode", 32'(testMode), 32'd0);
        checkOutput("abort clock_en", 32'(clockEn), 32'd1);
        checkOutput("abort signature", signature, 32'd0);
        doneCycle = -1;
      end
      scanOut = stimFor(mode, c);
    end
    scanOut = 2'b00;
  endtask

  task automatic runLong(output int busyCycles, output int doneCycle);
    busyCycles = 0;
    doneCycle = 0;
    @(negedge clk);
    startL = 1'b1;
    @(negedge clk);
    startL = 1'b0;
    for (int c = 1; c <= 200 && doneCycle == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (busyL) busyCycles++;
      if (doneL) doneCycle = c;
      scanOutL = (c == 23);
    end
    scanOutL = 1'b0;
  endtask

  initial begin
    int bc, dc;
    logic [31:0] expSig;
    rstN = 1'b0;
    start = 1'b0;
    scanOut = 2'b00;
    startL = 1'b0;
    scanOutL = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy_o", 32'(busy), 32'd0);
    checkOutput("reset done_o", 32'(done), 32'd0);
    checkOutput("reset pass_o", 32'(pass), 32'd0);
    checkOutput("reset test_mode_o", 32'(testMode), 32'd0);
    checkOutput("reset clock_en_o", 32'(clockEn), 32'd1);
    checkOutput("reset signature_o", signature, 32'd0);
    rstN = 1'b1;

    applyStimulus(0, 0, 0, bc, dc);
    checkOutput("zero run busy cycles", 32'(bc), 32'd21);
    checkOutput("zero run done cycle", 32'(dc), 32'd22);
    checkOutput("zero run signature", signature, 32'h0);
    checkOutput("zero run pass", 32'(pass), 32'd1);
    checkOutput("zero run pattern_cnt", 32'(patternCnt), 32'd3);

    applyStimulus(1, 0, 0, bc, dc);
    checkOutput("last unload bit signature", signature, 32'h1);
    checkOutput("last unload bit pass", 32'(pass), 32'd0);

    applyStimulus(2, 0, 0, bc, dc);
    checkOutput("pattern0 discard signature", signature, 32'h0);
    checkOutput("pattern0 discard pass", 32'(pass), 32'd1);

    applyStimulus(4, 0, 0, bc, dc);
    checkOutput("pattern1 first shift signature", signature, 32'h0000_1000);

    applyStimulus(4, 16, 0, bc, dc);
    applyStimulus(4, 0, 0, bc, dc);
    checkOutput("rerun after reset signature", signature, 32'h0000_1000);
    checkOutput("rerun after reset busy cycles", 32'(bc), 32'd21);

    applyStimulus(3, 0, 0, bc, dc);
    checkOutput("two unload bits signature", signature, 32'h3);

    expSig = 32'h0;
    for (int i = 0; i < 40; i++) expSig = misrModel(expSig, (i == 0) ? 32'd1 : 32'd0);
    runLong(bc, dc);
    checkOutput("long busy cycles", 32'(bc), 32'd64);
    checkOutput("long done cycle", 32'(dc), 32'd65);
    checkOutput("long signature", signatureL, expSig);
    checkOutput("long pattern_cnt", 32'(patternCntL), 32'd2);

`ifdef LBIST_ABORT_EN
    applyStimulus(3, 0, 18, bc, dc);
    applyStimulus(3, 0, 0, bc, dc);
    checkOutput("run after abort signature", signature, 32'h3);
    checkOutput("run after abort done cycle", 32'(dc), 32'd22);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lbist_ctrl.md
Name: lbist_ctrl

Overview:
- Parametrised logic-BIST controller for the RI5CY gate-level LBIST wrapper.
- Drives test_mode, scan-enable and core clock-enable.
- Feeds N_CHAINS scan chains from an LFSR pattern generator and compacts chain outputs in a MISR.
- Compares the final signature against a golden value. Sits between the testbench/top control and the scan-inserted core.

Parameters:
- N_CHAINS, 8, number of scan chains (1..LFSR_WIDTH, <= MISR_WIDTH)
- CHAIN_LEN, 64, flops per chain (longest chain; >=2)
- N_PATTERNS, 1024, patterns applied per run (>=1)
- LFSR_WIDTH, 32, pattern generator width
- LFSR_POLY, 32'h8020_0003, Fibonacci feedback taps (bit i set = tap on lfsr[i])
- LFSR_SEED, 32'hACE1_0001, LFSR load value (must be nonzero)
- MISR_WIDTH, 32, signature width
- MISR_POLY, 32'h04C1_1DB7, MISR feedback polynomial
- GOLDEN_SIG, 32'h0, expected signature

Ports:
- clk_i, in, 1, clock
- rst_ni, in, 1, reset. Asynchronous, active-low.
- start_i, in, 1, run request (level, sampled in IDLE/DONE)
- scan_out_i, in, N_CHAINS, chain outputs from core
- scan_in_o, out, N_CHAINS, chain inputs to core
- scan_en_o, out, 1, scan shift enable
- test_mode_o, out, 1, core test_mode
- clock_en_o, out, 1, core clock_en_i
- busy_o, out, 1, run in progress
- done_o, out, 1, run finished
- pass_o, out, 1, signature == GOLDEN_SIG (valid when done_o)
- signature_o, out, MISR_WIDTH, MISR contents
- pattern_cnt_o, out, $clog2(N_PATTERNS+1), patterns captured so far

Behaviour:
- Reset values:
  - all outputs 0, except clock_en_o = 1.
  - FSM = IDLE, lfsr = LFSR_SEED, misr = 0, counters = 0.
- States: IDLE, SEED, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
- IDLE: start_i=1 -> SEED.
- SEED (1 cycle): lfsr <= LFSR_SEED; misr <= 0; pattern_cnt <= 0; done_o, pass_o cleared -> SHIFT.
- SHIFT (CHAIN_LEN cycles):
  - scan_en_o = 1; lfsr advances one step per cycle.
  - scan_in_o[i] = lfsr[i] (current value).
  - MISR updates each cycle only when pattern_cnt >= 1; the first unload is pre-test state and is discarded.
  - Leaves for CAPTURE after the CHAIN_LEN-th cycle.
- CAPTURE (1 cycle): scan_en_o = 0; pattern_cnt++. If pattern_cnt reaches N_PATTERNS -> UNLOAD, else -> SHIFT.
- UNLOAD (CHAIN_LEN cycles): scan_en_o = 1; lfsr keeps advancing; MISR updates every cycle -> COMPARE.
- COMPARE (1 cycle): pass_o <= (misr == GOLDEN_SIG) -> DONE.
- DONE: done_o = 1; pass_o and signature_o held. start_i=1 -> SEED (rerun). Otherwise stay.
- LFSR step: feedback = XOR of (lfsr & LFSR_POLY); lfsr <= {lfsr[W-2:0], feedback}.
- MISR step: misr <= {misr[W-2:0],1'b0} ^ (misr[W-1] ? MISR_POLY : 0) ^ zero-extend(scan_out_i).
- busy_o = 1 in SEED..COMPARE.
- test_mode_o = 1 in SEED..COMPARE.
- clock_en_o:
  - 1 when test_mode_o = 0 (functional).
  - In test mode, 1 only in SHIFT, CAPTURE, UNLOAD.
- Timing: start_i is sampled at edge 0. busy_o is high for exactly 1 + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles; done_o rises on the next cycle.
- start_i while busy: ignored.
- rst_ni low mid-run: immediate return to reset values. No partial signature is retained.
- All outputs registered except scan_in_o (from lfsr reg), scan_en_o, test_mode_o, clock_en_o (decoded from the state register only, glitch-free).

Optional Feature:
- Macro: LBIST_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in any busy state -> next cycle IDLE.
  - done_o = 0, pass_o = 0, misr cleared, test_mode_o = 0, clock_en_o = 1.
  - abort_i has priority over start_i.
- Undefined: no abort_i port; a run can be stopped only by rst_ni.

Test Plan:
- Params N_CHAINS=2, CHAIN_LEN=4, N_PATTERNS=3, GOLDEN_SIG=0; scan_out_i tied 0; start pulse -> busy_o high 21 cycles, done_o rises cycle 22, signature_o=0, pass_o=1, pattern_cnt_o=3.
- Same params; scan_out_i[0]=1 only on last UNLOAD cycle -> signature_o=32'h1, pass_o=0.
- First SHIFT cycle after SEED -> scan_in_o=2'b01 (LFSR_SEED[1:0]). Second cycle -> LFSR_SEED<<1 | feedback bits. Checked against reference model for all 12 shift cycles.
- scan_out_i driven nonzero during pattern-0 SHIFT only -> signature_o=0 (discard rule).
- rst_ni low during CAPTURE of pattern 2 -> outputs at reset values, clock_en_o=1. New start reproduces the identical signature of an uninterrupted run.
- LBIST_ABORT_EN defined: abort_i during UNLOAD -> IDLE next cycle, done_o=0, test_mode_o=0. Subsequent run yields a normal signature.
